vga_timing_gen: RTL and testbench

Generates VGA raster timing for the 640x480 display: hsync, vsync, blank, and the DrawX/DrawY pixel coordinates consumed by color_mapper. It sits between the board clock and the colour/sprite logic, producing one pixel per pixel-clock-enable tick. It is the producer side of the DrawX/DrawY/blank interface that color_mapper reads.

---
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider, DrawX/DrawY counters, sync/blank and frame pulse.
// Optional feature macro VGA_FRAME_COUNT_EN adds a 16-bit frame_count output.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        pix_ce,
  output logic        hs,
  output logic        vs,
  output logic        blank,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             blank_q, blank_d;
  logic             fs_q, fs_d;

  // With CLK_DIV=1 div_q is stuck at 0 == DIV_LAST, so pix_ce stays high even in reset.
  assign pix_ce = (div_q == DIV_LAST);

  // Next-state counters; sync/blank decoded from the next position for zero skew.
  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    fs_d  = 1'b0;
    if (pix_ce) begin
      div_d = '0;
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d  = '0;
          fs_d = 1'b1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
    hs_d    = !((x_d >= HS_FIRST) && (x_d <= HS_LAST));
    vs_d    = !((y_d >= VS_FIRST) && (y_d <= VS_LAST));
    blank_d = (x_d >= H_VIS) || (y_d >= V_VIS);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      div_q   <= div_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fc_q;

  // Bumps on the wrap edge so the new count appears alongside frame_start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fc_q <= '0;
    end else if (fs_d) begin
      fc_q <= fc_q + 16'd1;
    end
  end

  assign frame_count = fc_q;
`endif

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign blank       = blank_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized-reset bench for vga_timing_gen: three parameter sets checked every Clk
// against an arithmetic model of the raster derived from the Clk count since reset.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        pix_ce;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        fs;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [15:0] fc;
  } obs_t;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        pix_ce [3];
  logic        hs     [3];
  logic        vs     [3];
  logic        blank  [3];
  logic        fs     [3];
  logic [9:0]  dx     [3];
  logic [9:0]  dy     [3];
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] fc     [3];
`endif

  int unsigned n;
  int unsigned checks;
  int unsigned errors;
  int unsigned len;

  always #5 Clk = ~Clk;

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_dut_a (
    .Clk(Clk), .Reset(Reset), .pix_ce(pix_ce[0]), .hs(hs[0]), .vs(vs[0]),
    .blank(blank[0]), .DrawX(dx[0]), .DrawY(dy[0]), .frame_start(fs[0])
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(fc[0])
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_VISIBLE(5), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(2)
  ) u_dut_b (
    .Clk(Clk), .Reset(Reset), .pix_ce(pix_ce[1]), .hs(hs[1]), .vs(vs[1]),
    .blank(blank[1]), .DrawX(dx[1]), .DrawY(dy[1]), .frame_start(fs[1])
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(fc[1])
`endif
  );

  vga_timing_gen u_dut_c (
    .Clk(Clk), .Reset(Reset), .pix_ce(pix_ce[2]), .hs(hs[2]), .vs(vs[2]),
    .blank(blank[2]), .DrawX(dx[2]), .DrawY(dy[2]), .frame_start(fs[2])
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(fc[2])
`endif
  );

  // Expected outputs after n Clk edges since the last reset edge.
  function automatic obs_t model(input int unsigned cyc, input int unsigned d,
                                 input int unsigned hv, input int unsigned hf,
                                 input int unsigned hsw, input int unsigned hb,
                                 input int unsigned vv, input int unsigned vf,
                                 input int unsigned vsw, input int unsigned vb);
    obs_t o;
    int unsigned ht, vt, f, p, x, y;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    f  = ht * vt;
    p  = cyc / d;
    x  = p % ht;
    y  = (p / ht) % vt;
    o.pix_ce = ((cyc % d) == d - 1);
    o.hs     = !((x >= hv + hf) && (x < hv + hf + hsw));
    o.vs     = !((y >= vv + vf) && (y < vv + vf + vsw));
    o.blank  = (x >= hv) || (y >= vv);
    o.fs     = (cyc > 0) && ((cyc % d) == 0) && ((p % f) == 0);
    o.x      = 10'(x);
    o.y      = 10'(y);
`ifdef VGA_FRAME_COUNT_EN
    o.fc     = 16'(p / f);
`else
    o.fc     = 16'd0;
`endif
    return o;
  endfunction

  function automatic obs_t observe(input int i);
    obs_t o;
    o.pix_ce = pix_ce[i];
    o.hs     = hs[i];
    o.vs     = vs[i];
    o.blank  = blank[i];
    o.fs     = fs[i];
    o.x      = dx[i];
    o.y      = dy[i];
`ifdef VGA_FRAME_COUNT_EN
    o.fc     = fc[i];
`else
    o.fc     = 16'd0;
`endif
    return o;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got ce=%b hs=%b vs=%b blank=%b fs=%b x=%0d y=%0d fc=%0d exp ce=%b hs=%b vs=%b blank=%b fs=%b x=%0d y=%0d fc=%0d",
               tag, n, got.pix_ce, got.hs, got.vs, got.blank, got.fs, got.x, got.y, got.fc,
               exp.pix_ce, exp.hs, exp.vs, exp.blank, exp.fs, exp.x, exp.y, exp.fc);
    end
  endtask

  // One Clk: drive Reset, take the edge, then compare all three instances.
  task automatic step(input logic rst);
    Reset = rst;
    @(posedge Clk);
    if (rst) n = 0;
    else     n++;
    #1;
    check("cfg_a", observe(0), model(n, 1, 8, 2, 2, 2, 4, 1, 1, 1));
    check("cfg_b", observe(1), model(n, 3, 5, 1, 2, 1, 3, 1, 1, 2));
    check("cfg_c", observe(2), model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33));
  endtask

  initial begin
    Reset  = 1'b1;
    n      = 0;
    checks = 0;
    errors = 0;
    repeat (3) step(1'b1);
    // Long first run: several default lines and many small-config frames.
    for (int i = 0; i < 3400; i++) step(1'b0);
    for (int s = 0; s < 24; s++) begin
      len = $urandom_range(40, 1500);
      for (int i = 0; i < int'(len); i++) step(1'b0);
      len = $urandom_range(1, 3);
      for (int i = 0; i < int'(len); i++) step(1'b1);
    end
    for (int i = 0; i < 500; i++) step(1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
